// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit.
// 32 cycles per op: shift-add multiply, restoring divide.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             writeHi,
   input  logic             writeLo,
   input  logic [WIDTH-1:0] writeData,
   output logic             busy,
   output logic             done,
   output logic             divByZero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [4:0]         cnt;
   logic               is_div;
   logic               neg_res;
   logic               neg_a;
   logic               dz_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   d_q;
   logic [2*WIDTH-1:0] acc;

   logic               accept;
   logic               last;
   logic               sgn;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;

   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     sub_diff;
   logic [2*WIDTH-1:0] acc_nxt;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;
   logic               res_dz;

   assign accept = start && (state != RUN);
   assign last   = (state == RUN) && (cnt == 5'd31);
   assign busy   = (state == RUN);
   // DONE always lasts exactly one cycle, so it doubles as the pulse
   assign done      = (state == DONE);
   assign divByZero = done && dz_q;

   // Signed ops work on magnitudes; signs are fixed up at the end
   assign sgn   = ~op[0];
   assign mag_a = (sgn && srcA[WIDTH-1]) ? -srcA : srcA;
   assign mag_b = (sgn && srcB[WIDTH-1]) ? -srcB : srcB;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == 5'd31) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One multiply or divide iteration on acc = {upper, lower}
   always_comb begin
      add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (acc[0] ? {1'b0, d_q} : '0);
      rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      sub_diff = rem_sh - {1'b0, d_q};
      if (!is_div)
         acc_nxt = {add_sum, acc[WIDTH-1:1]};
      else if (sub_diff[WIDTH])
         acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_nxt = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   // Sign correction and divide-by-zero override of the final value
   always_comb begin
      prod   = neg_res ? -acc_nxt : acc_nxt;
      quo    = acc_nxt[WIDTH-1:0];
      rem    = acc_nxt[2*WIDTH-1:WIDTH];
      res_dz = is_div && (d_q == '0);
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (is_div) begin
         res_lo = neg_res ? -quo : quo;
         res_hi = neg_a ? -rem : rem;
      end
      if (res_dz) begin
         res_lo = '1;
         res_hi = a_q;
      end
   end

   // Operand latch, iteration state and HI/LO registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_a   <= 1'b0;
         dz_q    <= 1'b0;
         a_q     <= '0;
         d_q     <= '0;
         acc     <= '0;
         hi      <= '0;
         lo      <= '0;
      end else if (accept) begin
         cnt     <= '0;
         is_div  <= op[1];
         neg_res <= sgn && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
         neg_a   <= sgn && srcA[WIDTH-1];
         a_q     <= srcA;
         d_q     <= mag_b;
         acc     <= {{WIDTH{1'b0}}, mag_a};
      end else if (state == RUN) begin
         cnt <= cnt + 5'd1;
         acc <= acc_nxt;
         if (last) begin
            hi   <= res_hi;
            lo   <= res_lo;
            dz_q <= res_dz;
         end
      end else begin
         if (writeHi) hi <= writeData;
         if (writeLo) lo <= writeData;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit.
// Expected HI/LO pushed on issue, popped on done.
module tb_mult_div_unit;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic        writeHi = 1'b0;
   logic        writeLo = 1'b0;
   logic [31:0] writeData = '0;
   logic        busy;
   logic        done;
   logic        divByZero;
   logic [31:0] hi;
   logic [31:0] lo;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .srcA      (srcA),
      .srcB      (srcB),
      .writeHi   (writeHi),
      .writeLo   (writeLo),
      .writeData (writeData),
      .busy      (busy),
      .done      (done),
      .divByZero (divByZero),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic exp_t model(input logic [1:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t        e;
      longint      sa;
      longint      sb_;
      longint      q;
      longint      r;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      e.dz = 1'b0;
      case (o)
         2'd0: begin
            p = 64'(sa * sb_);
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         2'd1: begin
            p = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         default: begin
            if (b == 0) begin
               e.hi = a;
               e.lo = 32'hFFFFFFFF;
               e.dz = 1'b1;
            end else if (o == 2'd2) begin
               q = sa / sb_;
               r = sa % sb_;
               e.lo = q[31:0];
               e.hi = r[31:0];
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
      endcase
      return e;
   endfunction

   // Called just after a falling edge; accepted at the next rising edge
   task automatic issue(input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b);
      op    = o;
      srcA  = a;
      srcB  = b;
      start = 1'b1;
      sb.push_back(model(o, a, b));
      @(posedge clk);
      #1;
      start = 1'b0;
      check("accept_busy", 64'(busy), 64'd1);
   endtask

   // Returns at the falling edge where done is seen
   task automatic wait_done(output int cyc);
      int guard;
      cyc = 0;
      guard = 0;
      do begin
         @(negedge clk);
         if (busy) cyc++;
         guard++;
      end while (!done && guard < 60);
      if (!done) check("done_timeout", 64'd0, 64'd1);
   endtask

   // Scoreboard: compare each result as done pulses
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_hi", 64'(hi), 64'(e.hi));
            check("sb_lo", 64'(lo), 64'(e.lo));
            check("sb_dz", 64'(divByZero), 64'(e.dz));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int seen;
      #1 rst = 1'b1;
      #2;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dz", 64'(divByZero), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // MULTU all-ones
      issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(cyc);
      check("multu_busy_cycles", 64'(cyc), 64'd32);
      check("multu_hi", 64'(hi), 64'hFFFFFFFE);
      check("multu_lo", 64'(lo), 64'h00000001);
      @(negedge clk);
      check("done_pulse_end", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);

      // MULT -3*7, then DIV -7/2 back-to-back
      issue(2'd0, 32'hFFFFFFFD, 32'd7);
      wait_done(cyc);
      check("mult_hi", 64'(hi), 64'hFFFFFFFF);
      check("mult_lo", 64'(lo), 64'hFFFFFFEB);
      issue(2'd2, 32'hFFFFFFF9, 32'd2);
      wait_done(cyc);
      check("b2b_cycles", 64'(cyc), 64'd32);
      check("div_lo", 64'(lo), 64'hFFFFFFFD);
      check("div_hi", 64'(hi), 64'hFFFFFFFF);

      // DIVU by zero, then DIV overflow case
      issue(2'd3, 32'd100, 32'd0);
      wait_done(cyc);
      check("dz_cycles", 64'(cyc), 64'd32);
      check("dz_flag", 64'(divByZero), 64'd1);
      check("dz_lo", 64'(lo), 64'hFFFFFFFF);
      check("dz_hi", 64'(hi), 64'd100);
      issue(2'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_done(cyc);
      check("ovf_dz", 64'(divByZero), 64'd0);
      check("ovf_lo", 64'(lo), 64'h80000000);
      check("ovf_hi", 64'(hi), 64'd0);
      @(negedge clk);

      // MTHI / MTLO in IDLE
      writeData = 32'h12345678;
      writeHi = 1'b1;
      @(posedge clk);
      #1 writeHi = 1'b0;
      check("mthi", 64'(hi), 64'h12345678);
      @(negedge clk);
      writeData = 32'h9ABCDEF0;
      writeLo = 1'b1;
      @(posedge clk);
      #1 writeLo = 1'b0;
      check("mtlo", 64'(lo), 64'h9ABCDEF0);
      check("mtlo_hi_kept", 64'(hi), 64'h12345678);
      @(negedge clk);
      writeData = 32'h000055AA;
      writeHi = 1'b1;
      writeLo = 1'b1;
      @(posedge clk);
      #1;
      writeHi = 1'b0;
      writeLo = 1'b0;
      check("mt_both_hi", 64'(hi), 64'h000055AA);
      check("mt_both_lo", 64'(lo), 64'h000055AA);

      // MT strobes during RUN are ignored
      @(negedge clk);
      issue(2'd1, 32'd5, 32'd6);
      @(negedge clk);
      writeData = 32'hDEADBEEF;
      writeHi = 1'b1;
      writeLo = 1'b1;
      repeat (3) @(negedge clk);
      writeHi = 1'b0;
      writeLo = 1'b0;
      check("mt_run_hi", 64'(hi), 64'h000055AA);
      check("mt_run_lo", 64'(lo), 64'h000055AA);
      wait_done(cyc);

      // start wins over MTHI on the accepting edge
      writeData = 32'hFFFF0000;
      writeHi = 1'b1;
      issue(2'd1, 32'd2, 32'd3);
      writeHi = 1'b0;
      check("start_over_mthi", 64'(hi), 64'd0);
      wait_done(cyc);
      @(negedge clk);

      // start and operand churn during RUN
      issue(2'd3, 32'd1000, 32'd7);
      repeat (5) begin
         @(negedge clk);
         start = 1'b1;
         srcA  = $urandom;
         srcB  = $urandom;
         op    = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      check("churn_lo", 64'(lo), 64'd142);
      check("churn_hi", 64'(hi), 64'd6);
      @(negedge clk);
      check("no_queued", 64'(busy), 64'd0);

      // Reset during iteration 10 aborts
      issue(2'd3, 32'd50, 32'd5);
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check("abort_no_done", 64'(seen), 64'd0);

      // First edge after reset release accepts start
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      issue(2'd3, 32'd50, 32'd5);
      wait_done(cyc);
      check("fresh_lo", 64'(lo), 64'd10);
      check("fresh_hi", 64'(hi), 64'd0);

      @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
